// File: rtl/systolic_acc_drain.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// systolic_acc_drain
//
// Result-side reader for the general_mac_pe systolic array. After a compute
// pass it takes over the broadcast accumulator mux select. It shifts the
// accumulated partial sums down the columns one row per accepted beat,
// captures the bottom-row acc_south values as one vector per row, and
// streams them out on a valid/ready interface, bottom row first. Once every
// row has been captured it clears all PE accumulators for one cycle. It then
// waits for the final beat to be accepted before reporting done.
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   start_i        single-cycle drain request, honoured only in IDLE
//   col_acc_i      acc_south of each bottom-row PE, column 0 in the LSBs
//   acc_mux_sel_o  broadcast PE select: 00 hold/MAC, 01 shift from north,
//                  11 clear
//   res_data_o     captured row vector (same packing as col_acc_i)
//   res_row_o      array row index of res_data_o
//   res_valid_o    result vector valid
//   res_ready_i    downstream accept
//   res_last_o     high with the row-0 vector (final beat)
//   busy_o         high from the cycle after an accepted start until done
//   done_o         one-cycle pulse once drain and clear are complete and the
//                  last beat has been accepted
// -----------------------------------------------------------------------------
module systolic_acc_drain #(
   parameter  int NumRows      = 4,
   parameter  int NumCols      = 4,
   parameter  int OutDataWidth = 32,
   localparam int RowW         = (NumRows > 1) ? $clog2(NumRows) : 1,
   localparam int VecW         = NumCols * OutDataWidth
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic signed [VecW-1:0] col_acc_i,
   output logic [1:0]             acc_mux_sel_o,
   output logic signed [VecW-1:0] res_data_o,
   output logic [RowW-1:0]        res_row_o,
   output logic                   res_valid_o,
   input  logic                   res_ready_i,
   output logic                   res_last_o,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam logic [1:0]      SelHold  = 2'b00;
   localparam logic [1:0]      SelShift = 2'b01;
   localparam logic [1:0]      SelClear = 2'b11;
   localparam logic [RowW-1:0] LastCnt  = RowW'(NumRows - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_CLEAR,
      ST_FLUSH
   } state_t;

   state_t          state;
   logic [RowW-1:0] cnt;
   logic            can_load;
   logic            capture;

   // The output register can take a new row when it is empty or being
   // emptied this cycle. A capture and an array shift always happen together.
   // As a result, the bottom row seen next cycle is always the next unread row.
   assign can_load = !res_valid_o || res_ready_i;
   assign capture  = (state == ST_DRAIN) && can_load;

   // The select is combinational on res_ready_i. The PE shifts at the same
   // edge that captures col_acc_i, so a stalled cycle must hold the array.
   always_comb begin
      acc_mux_sel_o = SelHold;
      case (state)
         ST_DRAIN: if (can_load) acc_mux_sel_o = SelShift;
         ST_CLEAR: acc_mux_sel_o = SelClear;
         default:  acc_mux_sel_o = SelHold;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         res_data_o  <= '0;
         res_row_o   <= '0;
         res_valid_o <= 1'b0;
         res_last_o  <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         done_o <= 1'b0;

         // Accepted beat empties the register; a capture below overrides this.
         if (res_valid_o && res_ready_i) res_valid_o <= 1'b0;

         if (capture) begin
            res_data_o  <= col_acc_i;
            res_row_o   <= LastCnt - cnt;
            res_valid_o <= 1'b1;
            res_last_o  <= (cnt == LastCnt);
            cnt         <= cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               // done_o high means the previous pass is still retiring.
               if (start_i && !done_o) begin
                  state  <= ST_DRAIN;
                  cnt    <= '0;
                  busy_o <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (capture && (cnt == LastCnt)) state <= ST_CLEAR;
            end
            ST_CLEAR: begin
               state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (!res_valid_o || res_ready_i) begin
                  done_o <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_acc_drain.sv
`timescale 1ns/1ps
// Bench for systolic_acc_drain: a 4x2 instance and a 1x1 instance, each fed
// by a behavioural PE-column model driven from the DUT select. Expected beats
// go into per-instance queues. A negedge monitor pops and compares them on
// every accepted beat.
module tb_systolic_acc_drain;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  row;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_ni   = 1'b0;
   logic start0   = 1'b0;
   logic start1   = 1'b0;
   logic rdy_main = 1'b1;
   logic pat_en   = 1'b0;
   logic pat_val  = 1'b1;
   logic rdy1     = 1'b1;
   logic rdy0;
   assign rdy0 = pat_en ? pat_val : rdy_main;

   // DUT 0: 4 rows x 2 columns
   logic [63:0] arr0 [4];
   logic [63:0] col0;
   logic [1:0]  sel0;
   logic [63:0] data0;
   logic [1:0]  row0;
   logic        vld0, last0, busy0, done0;
   logic        pre_en0  = 1'b0;
   logic [63:0] pre_row0 = '0;

   // DUT 1: 1 row x 1 column
   logic [31:0] arr1;
   logic [1:0]  sel1;
   logic [31:0] data1;
   logic [0:0]  row1;
   logic        vld1, last1, busy1, done1;
   logic        pre_en1  = 1'b0;
   logic [31:0] pre_val1 = '0;

   systolic_acc_drain #(.NumRows(4), .NumCols(2), .OutDataWidth(32)) dut0 (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start0), .col_acc_i(col0),
      .acc_mux_sel_o(sel0), .res_data_o(data0), .res_row_o(row0),
      .res_valid_o(vld0), .res_ready_i(rdy0), .res_last_o(last0),
      .busy_o(busy0), .done_o(done0));

   systolic_acc_drain #(.NumRows(1), .NumCols(1), .OutDataWidth(32)) dut1 (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start1), .col_acc_i(arr1),
      .acc_mux_sel_o(sel1), .res_data_o(data1), .res_row_o(row1),
      .res_valid_o(vld1), .res_ready_i(rdy1), .res_last_o(last1),
      .busy_o(busy1), .done_o(done1));

   // PE column models: row 0 takes the tied-zero north input (or the preload value).
   always @(posedge clk) begin
      if (pre_en0 || sel0 == 2'b01) begin
         arr0[0] <= pre_en0 ? pre_row0 : 64'd0;
         for (int r = 1; r < 4; r++) arr0[r] <= arr0[r-1];
      end else if (sel0 == 2'b11) begin
         for (int r = 0; r < 4; r++) arr0[r] <= 64'd0;
      end
      if (pre_en1) arr1 <= pre_val1;
      else if (sel1 == 2'b01 || sel1 == 2'b11) arr1 <= 32'd0;
   end
   assign col0 = arr0[3];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   beat_t q0[$];
   beat_t q1[$];
   int n01_0 = 0, n11_0 = 0, nbeat0 = 0, ndone0 = 0, done_cyc0 = 0;
   int n01_1 = 0, n11_1 = 0, nbeat1 = 0, ndone1 = 0, done_cyc1 = 0;
   int b01, b11, bbeat, bdone;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mk(input int c0, input int c1);
      return {c1, c0};
   endfunction

   // Ready pattern driver: 1,0,0,1,0,1 repeating while pat_en is set.
   initial begin
      logic pat [6];
      int   pidx;
      pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      pidx = 0;
      forever begin
         @(posedge clk);
         #1;
         if (pat_en) begin
            pat_val = pat[pidx];
            pidx    = (pidx + 1) % 6;
         end else begin
            pat_val = 1'b1;
            pidx    = 0;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      logic        pv0, pr0, pl0;
      logic [63:0] pd0;
      logic [1:0]  prow0;
      beat_t       e;
      pv0 = 1'b0; pr0 = 1'b0; pl0 = 1'b0; pd0 = '0; prow0 = '0;
      forever begin
         @(negedge clk);
         if (rst_ni) begin
            if (sel0 == 2'b01) n01_0++;
            if (sel0 == 2'b11) n11_0++;
            if (sel1 == 2'b01) n01_1++;
            if (sel1 == 2'b11) n11_1++;
            if (done0) begin ndone0++; done_cyc0 = cyc; end
            if (done1) begin ndone1++; done_cyc1 = cyc; end
            if (pv0 && !pr0) begin
               chk("stall_valid0", vld0, 1);
               chk("stall_data0", data0, pd0);
               chk("stall_row0", row0, prow0);
               chk("stall_last0", last0, pl0);
            end
            if (vld0 && !rdy0) chk("sel_is_shift_on_stall0", sel0 == 2'b01, 0);
            if (vld0 && rdy0) begin
               if (q0.size() == 0) chk("unexpected_beat0", 1, 0);
               else begin
                  e = q0.pop_front();
                  chk("beat_data0", data0, e.data);
                  chk("beat_row0", row0, e.row);
                  chk("beat_last0", last0, e.last);
                  nbeat0++;
               end
            end
            if (vld1 && rdy1) begin
               if (q1.size() == 0) chk("unexpected_beat1", 1, 0);
               else begin
                  e = q1.pop_front();
                  chk("beat_data1", {32'd0, data1}, e.data);
                  chk("beat_row1", row1, e.row);
                  chk("beat_last1", last1, e.last);
                  nbeat1++;
               end
            end
         end
         pv0 = vld0 && rst_ni; pr0 = rdy0; pd0 = data0; prow0 = row0; pl0 = last0;
      end
   end

   task automatic preload0();
      logic [63:0] rows [4];
      rows[0] = mk(7, -1);
      rows[1] = mk(300, -300);
      rows[2] = mk(0, 5);
      rows[3] = mk(-10, 10);
      for (int r = 3; r >= 0; r--) begin
         @(posedge clk); #1;
         pre_en0  = 1'b1;
         pre_row0 = rows[r];
      end
      @(posedge clk); #1;
      pre_en0 = 1'b0;
   endtask

   task automatic setup0();
      preload0();
      q0.push_back('{mk(-10, 10),   2'd3, 1'b0});
      q0.push_back('{mk(0, 5),      2'd2, 1'b0});
      q0.push_back('{mk(300, -300), 2'd1, 1'b0});
      q0.push_back('{mk(7, -1),     2'd0, 1'b1});
      b01 = n01_0; b11 = n11_0; bbeat = nbeat0; bdone = ndone0;
   endtask

   task automatic go0(output int c0);
      @(posedge clk); #1; start0 = 1'b1;
      @(posedge clk); #1; start0 = 1'b0;
      c0 = cyc;
   endtask

   task automatic finish0(input string nm, input int c0, input int lat);
      int k;
      k = 0;
      while (ndone0 == bdone && k < 60) begin
         @(posedge clk); #2;
         k++;
      end
      chk({nm, "_done_seen"}, ndone0 - bdone, 1);
      if (lat > 0) chk({nm, "_done_latency"}, done_cyc0 - c0, lat);
      chk({nm, "_busy_after_done"}, busy0, 0);
      chk({nm, "_shift_cycles"}, n01_0 - b01, 4);
      chk({nm, "_clear_cycles"}, n11_0 - b11, 1);
      chk({nm, "_beats"}, nbeat0 - bbeat, 4);
      chk({nm, "_queue_empty"}, q0.size(), 0);
      for (int r = 0; r < 4; r++) chk({nm, "_acc_cleared"}, arr0[r], 0);
   endtask

   initial begin
      int c0;
      int k;
      // Reset
      rst_ni = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel0", sel0, 0);
      chk("rst_valid0", vld0, 0);
      chk("rst_data0", data0, 0);
      chk("rst_row0", row0, 0);
      chk("rst_last0", last0, 0);
      chk("rst_busy0", busy0, 0);
      chk("rst_done0", done0, 0);
      chk("rst_valid1", vld1, 0);
      chk("rst_busy1", busy1, 0);
      rst_ni = 1'b1;

      // Full-throughput drain
      setup0();
      go0(c0);
      finish0("t1", c0, 6);

      // Toggling ready
      setup0();
      pat_en = 1'b1;
      go0(c0);
      finish0("t2", c0, 0);
      pat_en = 1'b0;

      // Ready low for 3 cycles after the final capture
      setup0();
      go0(c0);
      repeat (4) @(posedge clk);
      #1; rdy_main = 1'b0;
      repeat (3) @(posedge clk);
      #1; rdy_main = 1'b1;
      finish0("t3", c0, 8);

      // start_i during DRAIN and on the done cycle is ignored
      setup0();
      go0(c0);
      @(posedge clk); #1; start0 = 1'b1;
      @(posedge clk); #1; start0 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("t4_done_at_6", done0, 1);
      start0 = 1'b1;
      @(posedge clk); #1; start0 = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("t4_busy_idle", busy0, 0);
      chk("t4_beats", nbeat0 - bbeat, 4);
      chk("t4_shift_cycles", n01_0 - b01, 4);
      chk("t4_clear_cycles", n11_0 - b11, 1);
      chk("t4_done_count", ndone0 - bdone, 1);

      // Reset after the second beat, then a fresh pass
      setup0();
      go0(c0);
      repeat (2) @(posedge clk);
      #1; rst_ni = 1'b0;
      @(posedge clk); #1;
      chk("t5_rst_sel", sel0, 0);
      chk("t5_rst_valid", vld0, 0);
      chk("t5_rst_data", data0, 0);
      chk("t5_rst_row", row0, 0);
      chk("t5_rst_last", last0, 0);
      chk("t5_rst_busy", busy0, 0);
      chk("t5_rst_done", done0, 0);
      chk("t5_beats_before_rst", nbeat0 - bbeat, 1);
      rst_ni = 1'b1;
      while (q0.size() > 0) void'(q0.pop_front());
      setup0();
      go0(c0);
      finish0("t5b", c0, 6);

      // Single-row instance
      @(posedge clk); #1; pre_en1 = 1'b1; pre_val1 = -32'sd10;
      @(posedge clk); #1; pre_en1 = 1'b0;
      q1.push_back('{{32'd0, -32'sd10}, 2'd0, 1'b1});
      b01 = n01_1; b11 = n11_1; bbeat = nbeat1; bdone = ndone1;
      @(posedge clk); #1; start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      c0 = cyc;
      k = 0;
      while (ndone1 == bdone && k < 30) begin
         @(posedge clk); #2;
         k++;
      end
      chk("t6_done_seen", ndone1 - bdone, 1);
      chk("t6_done_latency", done_cyc1 - c0, 3);
      chk("t6_beats", nbeat1 - bbeat, 1);
      chk("t6_shift_cycles", n01_1 - b01, 1);
      chk("t6_clear_cycles", n11_1 - b11, 1);
      chk("t6_acc_cleared", arr1, 0);
      chk("t6_queue_empty", q1.size(), 0);
      chk("t6_busy", busy1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
